shift_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for one shared 32-bit logical shifter. The shifter has SHIFT32 semantics: 32-bit shift amount, LnR select, and a zero result when the amount is >= width.
- It captures the winning requester's operands and computes one shift per transaction.
- It returns a registered result through a req/done/ack handshake.
- It sits between the ALU-side requesters and the single barrel shifter instance, so the shifter does not have to be duplicated.

---
 rtl/shift_arbiter.sv | 134 +++++++++++++
 tb/tb_shift_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit logical shifter.
// Latency: REQ sampled -> GNT after that edge -> DONE/Y after the next edge; ACK edge frees it (3 cycles min).
// Backpressure: the result and DONE are held in RESP until the granted requester ACKs; other requests wait.
//
// Ports:
//   CLK, RST            clock and synchronous active-low reset
//   REQx/Dx/Sx/LNRx     requester x request, data, shift amount, direction (1 = left)
//   ACKx                requester x accepts its result
//   GNTx/DONEx          requester x owns the shifter / its result is valid on Y
//   Y                   registered shift result (kept after the transaction ends)
//   BUSY                high whenever the sequencer is not idle
module shift_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ0,
    input  logic [DATA_WIDTH-1:0]  D0,
    input  logic [SHAMT_WIDTH-1:0] S0,
    input  logic                   LNR0,
    input  logic                   ACK0,
    input  logic                   REQ1,
    input  logic [DATA_WIDTH-1:0]  D1,
    input  logic [SHAMT_WIDTH-1:0] S1,
    input  logic                   LNR1,
    input  logic                   ACK1,
    output logic                   GNT0,
    output logic                   GNT1,
    output logic                   DONE0,
    output logic                   DONE1,
    output logic [DATA_WIDTH-1:0]  Y,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The full shift amount is compared against the width, never a truncated copy.
    localparam logic [SHAMT_WIDTH-1:0] SHAMT_LIM = SHAMT_WIDTH'(DATA_WIDTH);

    state_t                 state;
    state_t                 state_nxt;
    logic                   ptr;        // requester that wins a tie
    logic                   win;        // requester owning the current transaction
    logic                   pick;
    logic                   ack_w;
    logic [DATA_WIDTH-1:0]  opnd_d;
    logic [SHAMT_WIDTH-1:0] opnd_s;
    logic                   opnd_lnr;
    logic [DATA_WIDTH-1:0]  shift_res;

    // Winner selection: a lone requester wins outright, a tie goes to ptr.
    always_comb begin
        pick = ptr;
        if (REQ0 && !REQ1) begin
            pick = 1'b0;
        end else if (!REQ0 && REQ1) begin
            pick = 1'b1;
        end
    end

    // Only the owner's ACK is ever looked at.
    assign ack_w = win ? ACK1 : ACK0;

    always_comb begin
        shift_res = '0;
        if (opnd_s < SHAMT_LIM) begin
            shift_res = opnd_lnr ? (opnd_d << opnd_s) : (opnd_d >> opnd_s);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ0 || REQ1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (ack_w) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            win      <= 1'b0;
            opnd_d   <= '0;
            opnd_s   <= '0;
            opnd_lnr <= 1'b0;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            DONE0    <= 1'b0;
            DONE1    <= 1'b0;
            Y        <= '0;
            BUSY     <= 1'b0;
        end else begin
            state <= state_nxt;
            // Registered copy of (state != IDLE), tracked from the next state.
            BUSY  <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (REQ0 || REQ1) begin
                        win      <= pick;
                        opnd_d   <= pick ? D1 : D0;
                        opnd_s   <= pick ? S1 : S0;
                        opnd_lnr <= pick ? LNR1 : LNR0;
                        GNT0     <= !pick;
                        GNT1     <= pick;
                    end
                end
                EXEC: begin
                    Y     <= shift_res;
                    DONE0 <= !win;
                    DONE1 <= win;
                end
                RESP: begin
                    if (ack_w) begin
                        GNT0  <= 1'b0;
                        GNT1  <= 1'b0;
                        DONE0 <= 1'b0;
                        DONE1 <= 1'b0;
                        ptr   <= !win;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed transactions, scoreboard queue checked on each DONE rise.
// Latency: inputs are driven 1 time unit after posedge; the monitor samples on negedge.
// Backpressure: ACK is delayed, pulsed from the wrong requester and held early to exercise RESP.
module tb_shift_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        REQ0 = 1'b0, REQ1 = 1'b0;
    logic [31:0] D0 = '0, D1 = '0, S0 = '0, S1 = '0;
    logic        LNR0 = 1'b0, LNR1 = 1'b0;
    logic        ACK0 = 1'b0, ACK1 = 1'b0;
    logic        GNT0, GNT1, DONE0, DONE1, BUSY;
    logic [31:0] Y;

    typedef struct packed {
        logic        who;
        logic [31:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic done_seen = 1'b0;

    shift_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .D0(D0), .S0(S0), .LNR0(LNR0), .ACK0(ACK0),
        .REQ1(REQ1), .D1(D1), .S1(S1), .LNR1(LNR1), .ACK1(ACK1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .Y(Y), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: every rising DONE pops one expectation.
    always @(negedge CLK) begin
        exp_t e;
        if ((DONE0 || DONE1) && !done_seen) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_who", {30'd0, DONE1, DONE0}, e.who ? 32'd2 : 32'd1);
                chk("sb_gnt", {30'd0, GNT1, GNT0}, e.who ? 32'd2 : 32'd1);
                chk("sb_y", Y, e.y);
            end
        end
        done_seen = (DONE0 === 1'b1) || (DONE1 === 1'b1);
    end

    task automatic drive(input logic who, input logic [31:0] d, input logic [31:0] s, input logic lnr);
        if (who) begin
            D1 = d; S1 = s; LNR1 = lnr; REQ1 = 1'b1;
        end else begin
            D0 = d; S0 = s; LNR0 = lnr; REQ0 = 1'b1;
        end
    endtask

    // One full transaction; operands are corrupted and REQ dropped right after the grant.
    task automatic do_txn(input logic who, input logic [31:0] d, input logic [31:0] s,
                          input logic lnr, input logic [31:0] exp_y, input int hold);
        int n;
        logic [31:0] y0;
        drive(who, d, s, lnr);
        exp_q.push_back('{who: who, y: exp_y});
        n = 0;
        while (((who ? GNT1 : GNT0) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        chk("grant_seen", {31'd0, who ? GNT1 : GNT0}, 32'd1);
        if (who) begin
            D1 = ~d; S1 = 32'd0; LNR1 = ~lnr; REQ1 = 1'b0;
        end else begin
            D0 = ~d; S0 = 32'd0; LNR0 = ~lnr; REQ0 = 1'b0;
        end
        tick();
        chk("exec_one_cycle", {31'd0, who ? DONE1 : DONE0}, 32'd1);
        y0 = Y;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                if (who) ACK0 = 1'b1; else ACK1 = 1'b1;
            end
            tick();
            ACK0 = 1'b0; ACK1 = 1'b0;
            chk("hold_done", {31'd0, who ? DONE1 : DONE0}, 32'd1);
            chk("hold_y", Y, y0);
        end
        if (who) ACK1 = 1'b1; else ACK0 = 1'b1;
        tick();
        ACK0 = 1'b0; ACK1 = 1'b0;
        chk("release", {29'd0, GNT1, GNT0, DONE1 | DONE0}, 32'd0);
        chk("release_busy", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        RST = 1'b0;
        tick(); tick();
        chk("rst_outs", {27'd0, GNT0, GNT1, DONE0, DONE1, BUSY}, 32'd0);
        chk("rst_y", Y, 32'd0);
        RST = 1'b1;
        tick();

        // Exact latency, with ACK0 already high during EXEC (must not shorten it)
        drive(1'b0, 32'd50, 32'd1, 1'b0);
        exp_q.push_back('{who: 1'b0, y: 32'd25});
        tick();
        chk("lat_gnt", {29'd0, GNT0, DONE0, BUSY}, 32'b101);
        REQ0 = 1'b0;
        ACK0 = 1'b1;
        tick();
        chk("lat_done", {29'd0, GNT0, DONE0, BUSY}, 32'b111);
        chk("lat_y", Y, 32'd25);
        tick();
        ACK0 = 1'b0;
        chk("lat_release", {29'd0, GNT0, DONE0, BUSY}, 32'd0);
        chk("lat_y_kept", Y, 32'd25);
        tick();

        // Directed single-requester vectors
        do_txn(1'b1, 32'd2000, 32'd1, 1'b1, 32'd4000, 0);
        do_txn(1'b1, 32'd2, 32'd20, 1'b1, 32'h0020_0000, 1);
        do_txn(1'b0, 32'd2, 32'd45, 1'b0, 32'd0, 0);
        do_txn(1'b0, 32'd200, 32'd15, 1'b0, 32'd0, 0);
        do_txn(1'b0, 32'h8000_0001, 32'd32, 1'b1, 32'd0, 0);
        do_txn(1'b0, 32'hFFFF_FFFF, 32'h0000_0021, 1'b0, 32'd0, 0);
        do_txn(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, 0);
        do_txn(1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 32'hDEAD_BEEF, 0);
        do_txn(1'b1, 32'hFFFF_FFFF, 32'd31, 1'b0, 32'd1, 0);
        do_txn(1'b0, 32'h1234_5679, 32'd4, 1'b1, 32'h2345_6790, 5);

        // Both requesters held from reset: grants alternate 0,1,0,1
        RST = 1'b0;
        D0 = 32'd500; S0 = 32'd2; LNR0 = 1'b0; REQ0 = 1'b1;
        D1 = 32'd1;   S1 = 32'd31; LNR1 = 1'b1; REQ1 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{who: i[0], y: i[0] ? 32'h8000_0000 : 32'd125});
        end
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (DONE0 !== 1'b1 && DONE1 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("alt_order", {30'd0, DONE1, DONE0}, i[0] ? 32'd2 : 32'd1);
            ACK0 = DONE0; ACK1 = DONE1;
            tick();
            ACK0 = 1'b0; ACK1 = 1'b0;
            if (i == 3) begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
        tick();

        // Serve 0 so the tie pointer moves to 1, then abort a second 0 transaction in RESP
        do_txn(1'b0, 32'd8, 32'd1, 1'b1, 32'd16, 0);
        drive(1'b0, 32'd7, 32'd1, 1'b1);
        exp_q.push_back('{who: 1'b0, y: 32'd14});
        tick();
        REQ0 = 1'b0;
        tick();
        chk("abort_pre_done", {31'd0, DONE0}, 32'd1);
        RST = 1'b0;
        tick();
        chk("abort_outs", {27'd0, GNT0, GNT1, DONE0, DONE1, BUSY}, 32'd0);
        chk("abort_y", Y, 32'd0);
        RST = 1'b1;
        D0 = 32'd3; S0 = 32'd3; LNR0 = 1'b1; REQ0 = 1'b1;
        D1 = 32'd9; S1 = 32'd1; LNR1 = 1'b1; REQ1 = 1'b1;
        exp_q.push_back('{who: 1'b0, y: 32'd24});
        tick();
        chk("ptr_reset_winner", {30'd0, GNT1, GNT0}, 32'd1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        ACK0 = 1'b1;
        tick();
        ACK0 = 1'b0;
        chk("final_release", {28'd0, GNT0, GNT1, DONE0, BUSY}, 32'd0);
        tick(); tick();

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
